// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_seq_pkg
// Description : Shared types and helpers for the matrix-multiply address
//               sequencer: FSM state encoding and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // $clog2 clamped to at least one bit so a count of 1 still gets a port.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_addr_sequencer_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-MAX up-counter. Increments on en, returns to 0 on
//               en while at MAX-1, and clears synchronously on clr (clr wins).
// Ports       : clk, reset_n (async, active-low)
//               en    - advance by one
//               clr   - force to zero next cycle
//               cnt   - current count, 0..MAX-1
//               last  - cnt == MAX-1
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(MAX - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_addr_sequencer
// Description : After data_rdy, walks NUM_PHASES phases of PHASE_LEN
//               addresses, presenting phase / idx / lin_addr with a
//               valid/ready handshake towards the multiply datapath.
//               Supports back-pressure, abort and continuous restart.
// Ports       : clk, reset_n        - clock, async active-low reset
//               data_rdy            - start request (IDLE / DONE)
//               dp_ready            - datapath takes current address
//               abort               - cancel current run
//               continuous          - restart from DONE when data_rdy
//               addr_valid          - phase/idx/lin_addr valid
//               phase, idx, lin_addr- address outputs
//               acc_clr / acc_last  - first / last address of a phase
//               busy                - not IDLE
//               data_done           - one-cycle run-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mult_addr_sequencer
  import mult_seq_pkg::*;
#(
  parameter  int NUM_PHASES = 4,
  parameter  int PHASE_LEN  = 36,
  localparam int PHASE_W    = clog2_min1(NUM_PHASES),
  localparam int IDX_W      = clog2_min1(PHASE_LEN),
  localparam int LIN_W      = clog2_min1(NUM_PHASES * PHASE_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_rdy,
  input  logic               dp_ready,
  input  logic               abort,
  input  logic               continuous,
  output logic               addr_valid,
  output logic [PHASE_W-1:0] phase,
  output logic [IDX_W-1:0]   idx,
  output logic [LIN_W-1:0]   lin_addr,
  output logic               acc_clr,
  output logic               acc_last,
  output logic               busy,
  output logic               data_done
);

  seq_state_t       state_q, state_d;
  logic [LIN_W-1:0] lin_q, lin_d;

  logic xfer;
  logic idx_last;
  logic phase_last;
  logic final_xfer;
  logic cnt_clr;

  assign xfer       = (state_q == RUN) && dp_ready && !abort;
  assign final_xfer = xfer && idx_last && phase_last;
  // Counters are only meaningful in RUN; holding them clear elsewhere
  // guarantees every run starts from zero regardless of how the last ended.
  assign cnt_clr    = (state_q != RUN) || abort;

  wrap_counter #(
    .MAX (PHASE_LEN),
    .W   (IDX_W)
  ) u_idx_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (xfer),
    .clr     (cnt_clr),
    .cnt     (idx),
    .last    (idx_last)
  );

  wrap_counter #(
    .MAX (NUM_PHASES),
    .W   (PHASE_W)
  ) u_phase_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (xfer && idx_last),
    .clr     (cnt_clr),
    .cnt     (phase),
    .last    (phase_last)
  );

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;

    if (cnt_clr) begin
      lin_d = '0;
    end else if (xfer) begin
      lin_d = final_xfer ? '0 : lin_q + LIN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (data_rdy) state_d = RUN;
      end
      RUN: begin
        if (abort)           state_d = IDLE;
        else if (final_xfer) state_d = DONE;
      end
      DONE: begin
        if (!abort && continuous && data_rdy) state_d = RUN;
        else                                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lin_q   <= '0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
    end
  end

  // Pure decode of registered state: no input reaches an output directly.
  assign addr_valid = (state_q == RUN);
  assign lin_addr   = lin_q;
  assign acc_clr    = addr_valid && (idx == '0);
  assign acc_last   = addr_valid && idx_last;
  assign busy       = (state_q != IDLE);
  assign data_done  = (state_q == DONE);

endmodule
`default_nettype wire
